// File: rtl/apb_i2c_master_arbiter.sv
// apb_i2c_master_arbiter
// Shares the APB-to-I2C bridge slave between two requesters:
//   requester 0 is the CPU command port, requester 1 is the DMA engine.
// Requesters are served round-robin. Each transfer runs SETUP then ACCESS,
// and the ACCESS wait on PREADY is bounded by TIMEOUT_CYC cycles.
// Every accepted command returns exactly one response, tagged with its
// requester ID and an error code.
module apb_i2c_master_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic        REQ0_WRITE,
    input  logic [31:0] REQ0_ADDR,
    input  logic [31:0] REQ0_WDATA,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic        REQ1_WRITE,
    input  logic [31:0] REQ1_ADDR,
    input  logic [31:0] REQ1_WDATA,
    output logic        RSP_VALID,
    output logic        RSP_ID,
    output logic [31:0] RSP_RDATA,
    output logic [1:0]  RSP_ERR,
    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        cur_id;
    logic [7:0]  wait_cnt;
    logic        gnt_id;
    logic        accept;
    logic        addr_legal;
    logic        timeout_hit;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Round-robin arbitration: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        gnt_id = ~last_grant;
        if (REQ0_VALID && !REQ1_VALID) begin
            gnt_id = 1'b0;
        end else if (!REQ0_VALID && REQ1_VALID) begin
            gnt_id = 1'b1;
        end
        accept      = (state == IDLE) && (REQ0_VALID || REQ1_VALID);
        REQ0_READY  = accept && !gnt_id;
        REQ1_READY  = accept && gnt_id;
        sel_write   = gnt_id ? REQ1_WRITE : REQ0_WRITE;
        sel_addr    = gnt_id ? REQ1_ADDR  : REQ0_ADDR;
        sel_wdata   = gnt_id ? REQ1_WDATA : REQ0_WDATA;
        addr_legal  = (sel_addr[31:4] == 28'd0) && (sel_addr[1:0] == 2'b00);
        timeout_hit = (wait_cnt == WAIT_LAST);
    end

    // Next-state logic; an illegal address skips the bus and goes straight to the response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = addr_legal ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered APB outputs, latched command, wait counter and response fields
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            wait_cnt   <= 8'd0;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= 32'd0;
            PWDATA     <= 32'd0;
            RSP_VALID  <= 1'b0;
            RSP_ID     <= 1'b0;
            RSP_RDATA  <= 32'd0;
            RSP_ERR    <= 2'b00;
        end else begin
            PSELx     <= (state_next == SETUP) || (state_next == ACCESS);
            PENABLE   <= (state_next == ACCESS);
            RSP_VALID <= (state_next == RESP);
            if (accept) begin
                last_grant <= gnt_id;
                cur_id     <= gnt_id;
                if (addr_legal) begin
                    PWRITE <= sel_write;
                    PADDR  <= sel_addr;
                    PWDATA <= sel_wdata;
                end else begin
                    RSP_ID    <= gnt_id;
                    RSP_RDATA <= 32'd0;
                    RSP_ERR   <= 2'b11;
                end
            end
            if (state == SETUP) begin
                wait_cnt <= 8'd0;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    RSP_ID    <= cur_id;
                    RSP_RDATA <= PWRITE ? 32'd0 : PRDATA;
                    RSP_ERR   <= PSLVERR ? 2'b01 : 2'b00;
                end else if (timeout_hit) begin
                    RSP_ID    <= cur_id;
                    RSP_RDATA <= 32'd0;
                    RSP_ERR   <= 2'b10;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_i2c_master_arbiter.sv
// tb_apb_i2c_master_arbiter
// Directed bench for the two-requester APB master: a small APB slave model
// answers with a programmable number of wait cycles, read data and error.
module tb_apb_i2c_master_arbiter;

    logic        PCLK;
    logic        PRESETn;
    logic        REQ0_VALID;
    logic        REQ0_READY;
    logic        REQ0_WRITE;
    logic [31:0] REQ0_ADDR;
    logic [31:0] REQ0_WDATA;
    logic        REQ1_VALID;
    logic        REQ1_READY;
    logic        REQ1_WRITE;
    logic [31:0] REQ1_ADDR;
    logic [31:0] REQ1_WDATA;
    logic        RSP_VALID;
    logic        RSP_ID;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_ERR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks   = 0;
    int failures = 0;

    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    int          acc_cnt   = 0;
    int          pen_cnt   = 0;
    int          psel_cnt  = 0;
    int          rsp_cnt   = 0;

    apb_i2c_master_arbiter #(.TIMEOUT_CYC(16)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_WRITE (REQ0_WRITE),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_WDATA (REQ0_WDATA),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_WRITE (REQ1_WRITE),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_WDATA (REQ1_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_ID     (RSP_ID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    // 100 MHz clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave model: PREADY rises after slv_wait extra ACCESS cycles
    assign PREADY  = PSELx && PENABLE && (acc_cnt == slv_wait);
    assign PSLVERR = slv_err;

    // Counts ACCESS cycles of the current transfer for the slave model
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
        end else if (PSELx && PENABLE && !PREADY) begin
            acc_cnt <= acc_cnt + 1;
        end else begin
            acc_cnt <= 0;
        end
    end

    // Running tallies of bus and response activity
    always @(posedge PCLK) begin
        if (PENABLE)   pen_cnt  <= pen_cnt + 1;
        if (PSELx)     psel_cnt <= psel_cnt + 1;
        if (RSP_VALID) rsp_cnt  <= rsp_cnt + 1;
    end

    // Global time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (port == 0) begin
            REQ0_VALID = 1'b1;
            REQ0_WRITE = wr;
            REQ0_ADDR  = addr;
            REQ0_WDATA = wdata;
        end else begin
            REQ1_VALID = 1'b1;
            REQ1_WRITE = wr;
            REQ1_ADDR  = addr;
            REQ1_WDATA = wdata;
        end
    endtask

    task automatic dropReq(input int port);
        if (port == 0) REQ0_VALID = 1'b0;
        else           REQ1_VALID = 1'b0;
    endtask

    task automatic waitGrant(output int who);
        who = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (REQ0_READY || REQ1_READY) begin
                checkOutput("ready_onehot", 32'(REQ0_READY & REQ1_READY), 32'd0);
                who = REQ1_READY ? 1 : 0;
                return;
            end
            step();
        end
    endtask

    task automatic waitRsp(output int cyc);
        cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (RSP_VALID) begin
                cyc = k;
                return;
            end
            step();
        end
    endtask

    initial begin
        int who;
        int cyc;
        int base_pen;
        int base_psel;
        int base_rsp;
        int n0;
        int n1;

        PRESETn    = 1'b1;
        REQ0_VALID = 1'b0;
        REQ0_WRITE = 1'b0;
        REQ0_ADDR  = 32'd0;
        REQ0_WDATA = 32'd0;
        REQ1_VALID = 1'b0;
        REQ1_WRITE = 1'b0;
        REQ1_ADDR  = 32'd0;
        REQ1_WDATA = 32'd0;
        PRDATA     = 32'd0;
        #2;
        PRESETn = 1'b0;
        step();
        step();
        checkOutput("rst_psel",   32'(PSELx),     32'd0);
        checkOutput("rst_penable",32'(PENABLE),   32'd0);
        checkOutput("rst_paddr",  PADDR,          32'd0);
        checkOutput("rst_rsp_v",  32'(RSP_VALID), 32'd0);
        checkOutput("rst_rsp_err",32'(RSP_ERR),   32'd0);
        PRESETn = 1'b1;
        step();

        // Single write from requester 0, PREADY on the first ACCESS cycle
        slv_wait = 0;
        applyStimulus(0, 1'b1, 32'd12, 32'h0000_2A5A);
        waitGrant(who);
        checkOutput("t1_grant", 32'(who), 32'd0);
        step();
        dropReq(0);
        checkOutput("t1_setup_psel", 32'(PSELx),   32'd1);
        checkOutput("t1_setup_pen",  32'(PENABLE), 32'd0);
        checkOutput("t1_setup_addr", PADDR,        32'd12);
        checkOutput("t1_setup_wr",   32'(PWRITE),  32'd1);
        checkOutput("t1_setup_wd",   PWDATA,       32'h0000_2A5A);
        step();
        checkOutput("t1_acc_psel",   32'(PSELx),   32'd1);
        checkOutput("t1_acc_pen",    32'(PENABLE), 32'd1);
        step();
        checkOutput("t1_rsp_v",      32'(RSP_VALID), 32'd1);
        checkOutput("t1_rsp_id",     32'(RSP_ID),    32'd0);
        checkOutput("t1_rsp_err",    32'(RSP_ERR),   32'd0);
        checkOutput("t1_rsp_rdata",  RSP_RDATA,      32'd0);
        checkOutput("t1_rsp_psel",   32'(PSELx),     32'd0);
        step();
        checkOutput("t1_rsp_pulse",  32'(RSP_VALID), 32'd0);
        checkOutput("t1_addr_hold",  PADDR,          32'd12);

        // Read from requester 1 with PREADY on the third ACCESS cycle
        slv_wait = 2;
        PRDATA   = 32'hDEAD_BEEF;
        base_pen = pen_cnt;
        applyStimulus(1, 1'b0, 32'd4, 32'd0);
        waitGrant(who);
        checkOutput("t3_grant", 32'(who), 32'd1);
        step();
        dropReq(1);
        waitRsp(cyc);
        checkOutput("t3_latency", 32'(cyc), 32'd4);
        checkOutput("t3_pen_cycles", 32'(pen_cnt - base_pen), 32'd3);
        checkOutput("t3_rsp_id",    32'(RSP_ID),  32'd1);
        checkOutput("t3_rsp_rdata", RSP_RDATA,    32'hDEAD_BEEF);
        checkOutput("t3_rsp_err",   32'(RSP_ERR), 32'd0);
        step();

        // Both requesters held valid for four commands each
        slv_wait = 0;
        PRDATA   = 32'h1234_5678;
        n0 = 0;
        n1 = 0;
        applyStimulus(0, 1'b1, 32'd0, 32'h0000_0100);
        applyStimulus(1, 1'b0, 32'd8, 32'd0);
        for (int i = 0; i < 8; i++) begin
            waitGrant(who);
            checkOutput("rr_grant", 32'(who), 32'(i % 2));
            step();
            if (who == 0) n0++;
            if (who == 1) n1++;
            if (n0 == 4) dropReq(0);
            if (n1 == 4) dropReq(1);
            waitRsp(cyc);
            checkOutput("rr_latency", 32'(cyc), 32'd2);
            checkOutput("rr_rsp_id",  32'(RSP_ID), 32'(i % 2));
        end
        dropReq(0);
        dropReq(1);
        step();

        // Read with PREADY never returned: sixteen ACCESS cycles then timeout
        slv_wait = 1000;
        PRDATA   = 32'hCAFE_F00D;
        base_pen = pen_cnt;
        applyStimulus(0, 1'b0, 32'd0, 32'd0);
        waitGrant(who);
        checkOutput("t4_grant", 32'(who), 32'd0);
        step();
        dropReq(0);
        waitRsp(cyc);
        checkOutput("t4_latency",   32'(cyc), 32'd17);
        checkOutput("t4_pen_cycles",32'(pen_cnt - base_pen), 32'd16);
        checkOutput("t4_rsp_err",   32'(RSP_ERR), 32'd2);
        checkOutput("t4_rsp_rdata", RSP_RDATA,    32'd0);
        checkOutput("t4_psel",      32'(PSELx),   32'd0);
        step();

        // Illegal address: immediate error response, no bus cycle
        slv_wait  = 0;
        base_psel = psel_cnt;
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'h5555_AAAA);
        waitGrant(who);
        checkOutput("t5_grant", 32'(who), 32'd0);
        step();
        dropReq(0);
        waitRsp(cyc);
        checkOutput("t5_latency", 32'(cyc), 32'd0);
        checkOutput("t5_rsp_err", 32'(RSP_ERR), 32'd3);
        checkOutput("t5_rsp_id",  32'(RSP_ID),  32'd0);
        step();
        checkOutput("t5_no_psel", 32'(psel_cnt - base_psel), 32'd0);
        checkOutput("t5_paddr_kept", PADDR, 32'd0);

        // Slave error on a write
        slv_err = 1'b1;
        applyStimulus(0, 1'b1, 32'd0, 32'h0000_00FF);
        waitGrant(who);
        step();
        dropReq(0);
        waitRsp(cyc);
        checkOutput("t6_rsp_err",   32'(RSP_ERR), 32'd1);
        checkOutput("t6_rsp_rdata", RSP_RDATA,    32'd0);
        slv_err = 1'b0;
        step();

        // Reset during ACCESS drops the bus and loses the command
        slv_wait = 1000;
        applyStimulus(1, 1'b0, 32'd8, 32'd0);
        waitGrant(who);
        checkOutput("t7_grant", 32'(who), 32'd1);
        step();
        dropReq(1);
        step();
        checkOutput("t7_in_access", 32'(PENABLE), 32'd1);
        base_rsp = rsp_cnt;
        PRESETn = 1'b0;
        #1;
        checkOutput("t7_rst_psel", 32'(PSELx),   32'd0);
        checkOutput("t7_rst_pen",  32'(PENABLE), 32'd0);
        step();
        step();
        PRESETn = 1'b1;
        step();
        step();
        checkOutput("t7_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
        slv_wait = 0;
        applyStimulus(0, 1'b1, 32'd4, 32'd1);
        applyStimulus(1, 1'b1, 32'd8, 32'd2);
        waitGrant(who);
        checkOutput("t7_post_grant", 32'(who), 32'd0);
        step();
        dropReq(0);
        dropReq(1);
        waitRsp(cyc);
        checkOutput("t7_post_rsp_id", 32'(RSP_ID), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
